// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronises and glitch-filters two encoder channels,
// decodes every legal Gray-code edge (x4) into a registered step/dir pair,
// keeps an 8-bit wrap-around position and flags illegal double transitions.
module quad_decoder #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_a,
    input  logic       in_b,
    input  logic       clear,
    output logic       step,
    output logic       dir,
    output logic [7:0] position,
    output logic       err
);
    // Filter counter value on which the pending level is accepted.
    localparam logic [3:0] FILT_LAST = 4'(FILTER_CYCLES - 1);

    typedef enum logic [1:0] {
        EV_NONE,
        EV_UP,
        EV_DOWN,
        EV_ILLEGAL
    } edge_ev_t;

    // Channel vectors are packed as {A, B}: bit 1 = A, bit 0 = B.
    logic [1:0] sync_q1;
    logic [1:0] sync_q2;
    logic [1:0] filt;
    logic [1:0] prev;
    logic [3:0] filt_cnt [2];
    logic [1:0] prime_cnt;
    logic       primed;
    logic       prime_load;
    logic [1:0] prev_idx;
    logic [1:0] cur_idx;
    logic [1:0] idx_delta;
    edge_ev_t   ev;

    assign primed     = (prime_cnt == 2'd3);
    assign prime_load = (prime_cnt == 2'd2);

    // Position of a Gray state along the forward cycle 00->10->11->01.
    function automatic logic [1:0] phase_idx(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Two-flop synchroniser per channel.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours, as real hardware does.
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {in_a, in_b};
            sync_q2 <= sync_q1;
        end
    end

    // Priming counter: saturates at 3 once the synchronisers hold real data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_cnt <= '0;
        end else if (!primed) begin
            prime_cnt <= prime_cnt + 2'd1;
        end
    end

    // Per-channel glitch filter; loads straight from the synchroniser when priming ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the filter counters form a two-entry array, but they are
            // control state that must start at zero, so they are reset like
            // ordinary flops rather than left uninitialised like a RAM.
            filt        <= '0;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else if (prime_load) begin
            filt        <= sync_q2;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else if (primed) begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q2[i] == filt[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FILT_LAST) begin
                    filt[i]     <= sync_q2[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Previous filtered state, compared against the current one each cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= '0;
        end else if (prime_load) begin
            prev <= sync_q2;
        end else if (primed) begin
            prev <= filt;
        end
    end

    // Classify the filtered transition by its distance along the Gray cycle.
    always_comb begin
        // NOTE: ev gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        ev        = EV_NONE;
        prev_idx  = phase_idx(prev);
        cur_idx   = phase_idx(filt);
        idx_delta = cur_idx - prev_idx;
        case (idx_delta)
            2'd1:    ev = EV_UP;
            2'd3:    ev = EV_DOWN;
            2'd2:    ev = EV_ILLEGAL;
            default: ev = EV_NONE;
        endcase
    end

    // Registered outputs; clear overrides position/err but not step/dir.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step     <= 1'b0;
            dir      <= 1'b1;
            position <= '0;
            err      <= 1'b0;
        end else begin
            step <= 1'b0;
            if (primed) begin
                case (ev)
                    EV_UP: begin
                        step     <= 1'b1;
                        dir      <= 1'b1;
                        position <= position + 8'd1;
                    end
                    EV_DOWN: begin
                        step     <= 1'b1;
                        dir      <= 1'b0;
                        position <= position - 8'd1;
                    end
                    EV_ILLEGAL: err <= 1'b1;
                    default:    ;
                endcase
            end
            if (clear) begin
                position <= '0;
                err      <= 1'b0;
            end
        end
    end

endmodule
